vga_char_fifo: RTL and testbench

VGA_CHAR_FIFO -- requirements
Module: vga_char_fifo

---
 rtl/vga_char_fifo.sv | 113 +++++++++++
 tb/tb_vga_char_fifo.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_char_fifo.sv
// Character FIFO between the AHB write path and the VGA text console, with a paced drain FSM.
// Optional macro VGA_CHAR_FIFO_OVF_CNT_EN adds ovf_cnt, a saturating count of dropped pushes.
module vga_char_fifo #(
  parameter int DEPTH = 16,
  parameter int GAP   = 0
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     scroll,
  output logic                     font_we,
  output logic [7:0]               font_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
`ifdef VGA_CHAR_FIFO_OVF_CNT_EN
  ,
  output logic [7:0]               ovf_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [3:0]    GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t          state;
  logic [3:0]      gap_cnt;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            pop;
  logic            push;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // A pop only ever happens on the IDLE -> ISSUE edge; a push into a full FIFO rides on it.
  assign pop  = (state == IDLE) && !empty && !scroll;
  assign push = wr_en && (!full || pop);

  // NOTE: the storage array has no reset; stale entries are unreachable once pointers and count clear.
  always_ff @(posedge HCLK) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= IDLE;
      gap_cnt   <= '0;
      font_we   <= 1'b0;
      font_data <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state     <= ISSUE;
            font_we   <= 1'b1;
            font_data <= mem[rd_ptr];
          end
        end
        ISSUE: begin
          font_we   <= 1'b0;
          font_data <= 8'h00;
          gap_cnt   <= '0;
          state     <= (GAP > 0) ? WAIT : IDLE;
        end
        WAIT: begin
          // Gap is a fixed edge count; scroll and pushes have no effect here.
          if (gap_cnt == GAP_LAST) state <= IDLE;
          else                     gap_cnt <= gap_cnt + 4'd1;
        end
        default: begin
          state     <= IDLE;
          font_we   <= 1'b0;
          font_data <= 8'h00;
        end
      endcase
    end
  end

`ifdef VGA_CHAR_FIFO_OVF_CNT_EN
  logic drop;
  assign drop = wr_en && full && !pop;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)                        ovf_cnt <= 8'h00;
    else if (drop && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_vga_char_fifo.sv
// Scoreboard bench for vga_char_fifo: one instance with GAP=0, one with GAP=3, shared clock/reset.
// Expected characters are queued at stimulus time; monitors pop and compare on every font_we strobe.
module tb_vga_char_fifo;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  always #5 HCLK = ~HCLK;

  logic       wr_en0 = 1'b0, wr_en1 = 1'b0;
  logic [7:0] wr_data0 = 8'h00, wr_data1 = 8'h00;
  logic       scroll0 = 1'b0, scroll1 = 1'b0;
  logic       font_we0, font_we1, full0, full1, empty0, empty1;
  logic [7:0] font_data0, font_data1;
  logic [4:0] count0, count1;
`ifdef VGA_CHAR_FIFO_OVF_CNT_EN
  logic [7:0] ovf0, ovf1;
`endif

  vga_char_fifo #(.DEPTH(16), .GAP(0)) u_g0 (
    .HCLK(HCLK), .HRESET(HRESET), .wr_en(wr_en0), .wr_data(wr_data0), .scroll(scroll0),
    .font_we(font_we0), .font_data(font_data0), .full(full0), .empty(empty0), .count(count0)
`ifdef VGA_CHAR_FIFO_OVF_CNT_EN
    , .ovf_cnt(ovf0)
`endif
  );

  vga_char_fifo #(.DEPTH(16), .GAP(3)) u_g3 (
    .HCLK(HCLK), .HRESET(HRESET), .wr_en(wr_en1), .wr_data(wr_data1), .scroll(scroll1),
    .font_we(font_we1), .font_data(font_data1), .full(full1), .empty(empty1), .count(count1)
`ifdef VGA_CHAR_FIFO_OVF_CNT_EN
    , .ovf_cnt(ovf1)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] sb0[$];
  logic [7:0] sb1[$];
  int ts1[$];
  logic prev_we0 = 1'b0;

  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: every strobe must match the head of its scoreboard queue.
  always @(negedge HCLK) begin
    if (font_we0) begin
      check("g0_back_to_back", 32'(prev_we0), 0);
      if (sb0.size() == 0) begin
        checks++; errors++;
        $display("FAIL g0_unexpected_strobe: got char %0h expected none", font_data0);
      end else check("g0_char", 32'(font_data0), 32'(sb0.pop_front()));
    end
    prev_we0 = font_we0;
  end

  always @(negedge HCLK) begin
    if (font_we1) begin
      ts1.push_back(cyc);
      if (sb1.size() == 0) begin
        checks++; errors++;
        $display("FAIL g3_unexpected_strobe: got char %0h expected none", font_data1);
      end else check("g3_char", 32'(font_data1), 32'(sb1.pop_front()));
    end
  end

  task automatic drain0();
    for (int i = 0; i < 100 && sb0.size() != 0; i++) @(negedge HCLK);
    check("g0_drain_done", sb0.size(), 0);
    repeat (2) @(negedge HCLK);
    check("g0_count_after_drain", 32'(count0), 0);
    check("g0_empty_after_drain", 32'(empty0), 1);
  endtask

  task automatic fill0(input logic [7:0] base, input int n, input int accept);
    for (int i = 0; i < n; i++) begin
      wr_en0 = 1'b1;
      wr_data0 = base + 8'(i);
      if (i < accept) sb0.push_back(base + 8'(i));
      @(negedge HCLK);
    end
    wr_en0 = 1'b0;
  endtask

  task automatic latency0(input logic [7:0] ch, input string tag);
    @(negedge HCLK);
    wr_data0 = ch; wr_en0 = 1'b1; sb0.push_back(ch);
    @(negedge HCLK);
    wr_en0 = 1'b0;
    check({tag, "_count_k"}, 32'(count0), 1);
    check({tag, "_we_k"}, 32'(font_we0), 0);
    @(negedge HCLK);
    check({tag, "_we_k1"}, 32'(font_we0), 1);
    check({tag, "_data_k1"}, 32'(font_data0), 32'(ch));
    @(negedge HCLK);
    check({tag, "_we_k2"}, 32'(font_we0), 0);
    check({tag, "_data_k2"}, 32'(font_data0), 0);
    check({tag, "_empty_k2"}, 32'(empty0), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(negedge HCLK);
    check("rst_we", 32'(font_we0), 0);
    check("rst_data", 32'(font_data0), 0);
    check("rst_count", 32'(count0), 0);
    check("rst_empty", 32'(empty0), 1);
    check("rst_full", 32'(full0), 0);
    check("rst_empty_g3", 32'(empty1), 1);
    HRESET = 1'b0;

    // Latency: push 0x41 -> strobe after next edge, cleared one edge later
    latency0(8'h41, "lat");

    // Overflow: 20 pushes while scroll is high, only the first 16 survive
    @(negedge HCLK);
    scroll0 = 1'b1;
    fill0(8'h00, 20, 16);
    check("ovf_full", 32'(full0), 1);
    check("ovf_count", 32'(count0), 16);
`ifdef VGA_CHAR_FIFO_OVF_CNT_EN
    check("ovf_cnt", 32'(ovf0), 4);
`endif
    scroll0 = 1'b0;
    drain0();

    // Simultaneous push and pop on a full FIFO
    scroll0 = 1'b1;
    fill0(8'h20, 16, 16);
    check("sim_full_before", 32'(full0), 1);
    scroll0 = 1'b0;
    wr_en0 = 1'b1; wr_data0 = 8'h30; sb0.push_back(8'h30);
    @(negedge HCLK);
    wr_en0 = 1'b0;
    check("sim_count", 32'(count0), 16);
    check("sim_full", 32'(full0), 1);
    check("sim_we", 32'(font_we0), 1);
`ifdef VGA_CHAR_FIFO_OVF_CNT_EN
    check("sim_ovf_cnt", 32'(ovf0), 4);
`endif
    drain0();

    // Scroll: first strobe, then scroll held for 10 cycles, then the remaining two
    scroll0 = 1'b1;
    fill0(8'h50, 3, 3);
    scroll0 = 1'b0;
    @(negedge HCLK);
    check("scr_first_we", 32'(font_we0), 1);
    scroll0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge HCLK);
      check("scr_hold_we", 32'(font_we0), 0);
    end
    check("scr_count_held", 32'(count0), 2);
    scroll0 = 1'b0;
    @(negedge HCLK);
    check("scr_resume_we", 32'(font_we0), 1);
    drain0();

    // Gap: GAP=3 instance, strobes 5 cycles apart
    scroll1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_en1 = 1'b1; wr_data1 = 8'h60 + 8'(i); sb1.push_back(8'h60 + 8'(i));
      @(negedge HCLK);
    end
    wr_en1 = 1'b0;
    ts1.delete();
    scroll1 = 1'b0;
    for (int i = 0; i < 100 && sb1.size() != 0; i++) @(negedge HCLK);
    check("gap_drain_done", sb1.size(), 0);
    check("gap_strobes", ts1.size(), 4);
    if (ts1.size() == 4)
      for (int i = 1; i < 4; i++) check("gap_spacing", ts1[i] - ts1[i-1], 5);
    repeat (8) @(negedge HCLK);
    check("gap_count_end", 32'(count1), 0);

    // Reset mid-stream, during an issued strobe with entries still queued
    scroll0 = 1'b1;
    fill0(8'h70, 4, 4);
    scroll0 = 1'b0;
    for (int i = 0; i < 10 && !font_we0; i++) @(negedge HCLK);
    check("mid_pre_strobe", 32'(font_we0), 1);
    #2;
    HRESET = 1'b1;
    sb0.delete();
    #1;
    check("mid_rst_we", 32'(font_we0), 0);
    check("mid_rst_data", 32'(font_data0), 0);
    check("mid_rst_count", 32'(count0), 0);
    check("mid_rst_empty", 32'(empty0), 1);
    check("mid_rst_full", 32'(full0), 0);
`ifdef VGA_CHAR_FIFO_OVF_CNT_EN
    check("mid_rst_ovf", 32'(ovf0), 0);
    check("mid_rst_ovf_g3", 32'(ovf1), 0);
`endif
    @(negedge HCLK);
    check("mid_rst_held_count", 32'(count0), 0);
    HRESET = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge HCLK);
      check("post_rst_no_we", 32'(font_we0), 0);
    end
    latency0(8'h77, "post");

    repeat (4) @(negedge HCLK);
    check("final_sb0_empty", sb0.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
